// File: rtl/kbd_scan_pkg.sv
// Shared defaults and helpers for the keypad scanner: board-level default
// geometry/timing constants and the lowest-set-bit priority encoder.
package kbd_scan_pkg;

  localparam int DEF_ROWS     = 4;
  localparam int DEF_COLS     = 4;
  localparam int DEF_SCAN_DIV = 1000;
  localparam int DEF_DEBOUNCE = 3;
  localparam int MAX_KEYS     = 64;

  typedef logic [3:0] stable_t;

  // Index of the lowest set bit, or MAX_KEYS when the vector is empty.
  function automatic int first_set(input logic [MAX_KEYS-1:0] v);
    int idx;
    idx = MAX_KEYS;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = i;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/kbd_tick.sv
// Column-slot divider: a registered one-cycle strobe during the last cycle
// of every SCAN_DIV-cycle slot.
module kbd_tick
  import kbd_scan_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] LAST = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] PRE  = TW'(SCAN_DIV - 2);

  logic [TW-1:0] cnt_r;
  logic          tick_r;

  // slot counter with the strobe pre-decoded one cycle ahead
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= {TW{1'b0}};
      tick_r <= 1'b0;
    end else begin
      if (cnt_r == LAST) begin
        cnt_r <= {TW{1'b0}};
      end else begin
        cnt_r <= cnt_r + TW'(1'b1);
      end
      tick_r <= (cnt_r == PRE);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/kbd_scan.sv
// Keypad matrix scanner: column drive, whole-frame debounce, lowest-index
// press encoder and a one-entry valid/ack holding register.
module kbd_scan
  import kbd_scan_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int DEBOUNCE = DEF_DEBOUNCE,
  localparam int KW      = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ack,
  output logic            key_down,
  output logic            overrun
);

  localparam int NK = ROWS * COLS;
  localparam int CW = $clog2(COLS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  logic [ROWS-1:0] row_meta_r, row_sync_r;
  logic [CW-1:0]   col_idx_r, col_idx_next_s;
  logic [COLS-1:0] col_r;
  logic [NK-1:0]   snap_r, snap_next_s, prev_r, deb_r, press_s;
  stable_t         stable_r;
  logic [KW-1:0]   code_r, event_code_s;
  logic            valid_r, down_r, overrun_r;
  logic            tick_s, frame_end_s, same_s, accept_s, event_s;
  int              first_s;

  kbd_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  // two-flop synchronizer; idle state is the pulled-up level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta_r <= {ROWS{1'b1}};
      row_sync_r <= {ROWS{1'b1}};
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
    end
  end

  // merge the active column's (active-high) samples into the snapshot
  always_comb begin
    snap_next_s = snap_r;
    for (int r = 0; r < ROWS; r++) begin
      snap_next_s[r*COLS + int'(col_idx_r)] = ~row_sync_r[r];
    end
  end

  assign frame_end_s    = tick_s && (col_idx_r == LAST_COL);
  assign same_s         = (snap_next_s == prev_r);
  assign col_idx_next_s = (col_idx_r == LAST_COL) ? {CW{1'b0}} : col_idx_r + CW'(1'b1);

  // accept once DEBOUNCE consecutive frames agree
  always_comb begin
    if (!frame_end_s) begin
      accept_s = 1'b0;
    end else if (DEBOUNCE == 1) begin
      accept_s = 1'b1;
    end else begin
      accept_s = same_s && (int'(stable_r) >= DEBOUNCE - 2);
    end
  end

  // newly pressed keys; only the lowest index becomes an event
  always_comb begin
    if (accept_s) begin
      press_s = snap_next_s & ~deb_r;
    end else begin
      press_s = {NK{1'b0}};
    end
    first_s      = first_set(MAX_KEYS'(press_s));
    event_s      = (first_s < NK);
    event_code_s = KW'(first_s);
  end

  // column sequencing, snapshot capture and frame debounce
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_idx_r <= {CW{1'b0}};
      col_r     <= ~COLS'(1'b1);
      snap_r    <= {NK{1'b0}};
      prev_r    <= {NK{1'b0}};
      deb_r     <= {NK{1'b0}};
      stable_r  <= 4'd0;
      down_r    <= 1'b0;
    end else if (tick_s) begin
      col_idx_r <= col_idx_next_s;
      col_r     <= ~(COLS'(1'b1) << col_idx_next_s);
      snap_r    <= snap_next_s;
      if (frame_end_s) begin
        prev_r <= snap_next_s;
        if (!same_s) begin
          stable_r <= 4'd0;
        end else if (stable_r < stable_t'(DEBOUNCE)) begin
          stable_r <= stable_r + 4'd1;
        end else begin
          stable_r <= stable_r;
        end
        if (accept_s) begin
          deb_r  <= snap_next_s;
          down_r <= |snap_next_s;
        end else begin
          deb_r  <= deb_r;
          down_r <= down_r;
        end
      end else begin
        prev_r   <= prev_r;
        stable_r <= stable_r;
      end
    end else begin
      col_idx_r <= col_idx_r;
    end
  end

  // holding register: an ack in the same cycle as an event makes room for it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_r    <= {KW{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else if (event_s) begin
      if (key_ack) begin
        code_r    <= event_code_s;
        valid_r   <= 1'b1;
        overrun_r <= 1'b0;
      end else if (valid_r) begin
        overrun_r <= 1'b1;
      end else begin
        code_r  <= event_code_s;
        valid_r <= 1'b1;
      end
    end else if (key_ack) begin
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign col       = col_r;
  assign key_code  = code_r;
  assign key_valid = valid_r;
  assign key_down  = down_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_kbd_scan.sv
// Bench for kbd_scan (4x4, SCAN_DIV=4, DEBOUNCE=2): a keypad model drives the
// rows and a frame-level reference model predicts the port-side outputs.
module tb_kbd_scan;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int FRAME    = ROWS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset, key_ack, key_valid, key_down, overrun;
  logic [3:0]  row, col, key_code;
  logic [15:0] pressed;
  int          checks = 0;
  int          errors = 0;

  logic [15:0] m_prev, m_deb;
  int          m_run;
  logic        m_valid, m_ovr;
  logic [3:0]  m_code;

  kbd_scan #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_down  (key_down),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // keypad: a pressed key shorts its row to its column while that column is low
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS + c] && !col[c]) row[r] = 1'b0;
  end

  function automatic int lowest(input logic [15:0] v);
    int k;
    k = -1;
    for (int i = 15; i >= 0; i--) if (v[i]) k = i;
    return k;
  endfunction

  task automatic m_reset();
    m_prev = 16'h0; m_deb = 16'h0; m_run = 1;
    m_valid = 1'b0; m_ovr = 1'b0; m_code = 4'd0;
  endtask

  // reference: one whole frame with snapshot 'snap' has just ended
  task automatic m_frame(input logic [15:0] snap, input bit ack);
    int ev;
    ev = -1;
    if (snap == m_prev) m_run++; else m_run = 1;
    m_prev = snap;
    if (m_run >= DEBOUNCE) begin
      ev = lowest(snap & ~m_deb);
      m_deb = snap;
    end
    if (ev >= 0) begin
      if (ack) begin m_valid = 1'b1; m_code = 4'(ev); m_ovr = 1'b0; end
      else if (m_valid) m_ovr = 1'b1;
      else begin m_valid = 1'b1; m_code = 4'(ev); end
    end else if (ack) begin
      m_valid = 1'b0; m_ovr = 1'b0;
    end
  endtask

  // one aligned frame; optional ack on its first edge and/or its frame-end edge
  task automatic run_frame(input logic [15:0] keys, input bit ack_early, input bit ack_late);
    pressed = keys;
    key_ack = ack_early;
    @(posedge clk); #1 key_ack = 1'b0;
    if (ack_early) begin m_valid = 1'b0; m_ovr = 1'b0; end
    repeat (FRAME - 2) @(posedge clk);
    #1 key_ack = ack_late;
    @(posedge clk); #1 key_ack = 1'b0;
    m_frame(keys, ack_late);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; pressed = 16'h0; key_ack = 1'b0;
    @(negedge clk); reset = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    logic [3:0] one, exp_col;
    one = 4'b0001;
    run_frame(16'h0080, 1'b0, 1'b0);
    run_frame(16'h0080, 1'b0, 1'b0);
    checks++; if (key_valid !== m_valid || key_code !== m_code || key_down !== 1'b1) begin
      errors++; $display("FAIL pre_reset valid/code/down got %b/%0d/%b exp %b/%0d/1", key_valid, key_code, key_down, m_valid, m_code);
    end
    @(posedge clk); #3 reset = 1'b1; pressed = 16'h0;
    #1;
    checks++; if (col !== 4'b1110 || key_valid !== 1'b0 || overrun !== 1'b0 || key_down !== 1'b0 || key_code !== 4'd0) begin
      errors++; $display("FAIL reset_values col=%b valid=%b ovr=%b down=%b code=%0d exp 1110/0/0/0/0", col, key_valid, overrun, key_down, key_code);
    end
    @(negedge clk); reset = 1'b0;
    m_reset();
    for (int e = 1; e <= FRAME; e++) begin
      @(posedge clk); #1;
      exp_col = ~(one << ((e / SCAN_DIV) % COLS));
      checks++; if (col !== exp_col) begin
        errors++; $display("FAIL col_step edge %0d got %b exp %b", e, col, exp_col);
      end
    end
    m_frame(16'h0, 1'b0);
  endtask

  task automatic test_single_press();
    run_frame(16'h0200, 1'b0, 1'b0);
    checks++; if (key_valid !== 1'b0) begin
      errors++; $display("FAIL single_early valid got %b exp 0", key_valid);
    end
    run_frame(16'h0200, 1'b0, 1'b0);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd9 || key_down !== 1'b1) begin
      errors++; $display("FAIL single_press valid/code/down got %b/%0d/%b exp 1/9/1", key_valid, key_code, key_down);
    end
    pressed = 16'h0200; key_ack = 1'b1;
    @(posedge clk); #1 key_ack = 1'b0;
    m_valid = 1'b0; m_ovr = 1'b0;
    checks++; if (key_valid !== 1'b0) begin
      errors++; $display("FAIL single_ack valid got %b exp 0", key_valid);
    end
    repeat (FRAME - 1) @(posedge clk); #1;
    m_frame(16'h0200, 1'b0);
    run_frame(16'h0000, 1'b0, 1'b0);
    checks++; if (key_down !== m_deb[9]) begin
      errors++; $display("FAIL release_hold down got %b exp %b", key_down, m_deb[9]);
    end
    run_frame(16'h0000, 1'b0, 1'b0);
    checks++; if (key_down !== 1'b0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL release down/valid got %b/%b exp 0/0", key_down, key_valid);
    end
  endtask

  task automatic test_bounce();
    for (int f = 0; f < 10; f++) begin
      run_frame((f % 2 == 0) ? 16'h0200 : 16'h0000, 1'b0, 1'b0);
      checks++; if (key_valid !== 1'b0 || key_down !== 1'b0 || key_valid !== m_valid) begin
        errors++; $display("FAIL bounce frame %0d valid/down got %b/%b exp 0/0", f, key_valid, key_down);
      end
    end
  endtask

  task automatic test_simultaneous();
    run_frame(16'h1008, 1'b0, 1'b0);
    run_frame(16'h1008, 1'b0, 1'b0);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd3 || overrun !== 1'b0) begin
      errors++; $display("FAIL simultaneous valid/code/ovr got %b/%0d/%b exp 1/3/0", key_valid, key_code, overrun);
    end
    run_frame(16'h0000, 1'b1, 1'b0);
    run_frame(16'h0000, 1'b0, 1'b0);
    checks++; if (key_valid !== 1'b0 || key_down !== 1'b0) begin
      errors++; $display("FAIL simul_release valid/down got %b/%b exp 0/0", key_valid, key_down);
    end
  endtask

  task automatic test_overrun();
    run_frame(16'h0020, 1'b0, 1'b0);
    run_frame(16'h0020, 1'b0, 1'b0);
    run_frame(16'h0000, 1'b0, 1'b0);
    run_frame(16'h0000, 1'b0, 1'b0);
    run_frame(16'h0040, 1'b0, 1'b0);
    run_frame(16'h0040, 1'b0, 1'b0);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd5 || overrun !== 1'b1) begin
      errors++; $display("FAIL overrun valid/code/ovr got %b/%0d/%b exp 1/5/1", key_valid, key_code, overrun);
    end
    run_frame(16'h0040, 1'b1, 1'b0);
    checks++; if (key_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_ack valid/ovr got %b/%b exp 0/0", key_valid, overrun);
    end
  endtask

  task automatic test_collision();
    run_frame(16'h0000, 1'b0, 1'b0);
    run_frame(16'h0000, 1'b0, 1'b0);
    run_frame(16'h0020, 1'b0, 1'b0);
    run_frame(16'h0020, 1'b0, 1'b0);
    run_frame(16'h0000, 1'b0, 1'b0);
    run_frame(16'h0000, 1'b0, 1'b0);
    run_frame(16'h0040, 1'b0, 1'b0);
    run_frame(16'h0040, 1'b0, 1'b1);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd6 || overrun !== 1'b0) begin
      errors++; $display("FAIL collision valid/code/ovr got %b/%0d/%b exp 1/6/0", key_valid, key_code, overrun);
    end
  endtask

  task automatic test_random();
    logic [15:0] keys;
    int sel;
    keys = 16'h0;
    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(0, 5);
      if (sel == 3) keys = 16'h0;
      else if (sel == 4) keys = 16'h1 << $urandom_range(0, 15);
      else if (sel == 5) keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      run_frame(keys, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      checks++; if (key_valid !== m_valid || overrun !== m_ovr || key_down !== (|m_deb)
                    || (m_valid && key_code !== m_code)) begin
        errors++; $display("FAIL random frame %0d valid/code/ovr/down got %b/%0d/%b/%b exp %b/%0d/%b/%b",
                           f, key_valid, key_code, overrun, key_down, m_valid, m_code, m_ovr, |m_deb);
      end
    end
  endtask

  task automatic test_latency();
    int k, seen;
    for (int t = 0; t < 4; t++) begin
      do_reset();
      k = $urandom_range(0, 15);
      repeat ($urandom_range(0, 31)) @(posedge clk);
      #1 pressed = 16'h1 << k;
      seen = 0;
      for (int n = 1; n <= 3*FRAME + 3 && seen == 0; n++) begin
        @(posedge clk); #1;
        if (key_valid === 1'b1) seen = n;
      end
      checks++; if (seen == 0 || key_code !== 4'(k)) begin
        errors++; $display("FAIL latency key %0d seen_at %0d code %0d exp code %0d within %0d", k, seen, key_code, k, 3*FRAME + 3);
      end
    end
    do_reset();
  endtask

  initial begin
    reset = 1'b1; key_ack = 1'b0; pressed = 16'h0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_overrun();
    test_collision();
    test_random();
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
